// File: rtl/video_pkg.sv
// Shared video-path types for the pixel-domain stages.
//   rgb_t        : 24-bit packed RGB colour
//   fifo_word_t  : pixel FIFO word, {sof, rgb}; sof marks the first pixel of a frame
//   src_state_t  : pixel-source FSM state encoding
//   SOF_BIT      : bit position of the SOF tag inside a raw FIFO word
package video_pkg;

   typedef logic [23:0] rgb_t;

   typedef struct packed {
      logic sof;
      rgb_t rgb;
   } fifo_word_t;

   typedef enum logic [2:0] {
      SYNC     = 3'd0,
      ARMED    = 3'd1,
      WAIT_ACT = 3'd2,
      STREAM   = 3'd3,
      CHECK    = 3'd4
   } src_state_t;

   localparam int SOF_BIT = 24;

endpackage

// File: rtl/vga_pixel_source_if.sv
// FWFT pixel FIFO read port.
//   fifo_rdata : head word, [SOF_BIT] = SOF tag, [23:0] = RGB; valid while fifo_empty=0
//   fifo_empty : FIFO holds no words
//   fifo_read  : pop the head word in this cycle
// Modports: master = FIFO side, slave = reader side.
interface vga_pixel_source_if;
   import video_pkg::*;

   logic [SOF_BIT:0] fifo_rdata;
   logic             fifo_empty;
   logic             fifo_read;

   modport master (output fifo_rdata, output fifo_empty, input fifo_read);
   modport slave  (input fifo_rdata, input fifo_empty, output fifo_read);

endinterface

// File: rtl/vga_pixel_source.sv
// Pixel source feeding the VGA output stage. Pops RGB words from a FWFT FIFO,
// locks onto frames using the SOF tag, and re-aligns the pixel stream to the
// incoming HS/VS/BLANK timing with a one-cycle registered pipeline.
//
// Ports:
//   pixel_clk, pixel_rst_n      : clock, synchronous active-low reset
//   hs_in, vs_in, blank_in      : timing in (syncs active-low, blank_in=1 active)
//   fifo                        : FIFO read port (vga_pixel_source_if.slave)
//   err_clr                     : clears the sticky error flags
//   hs_out, vs_out, blank_out   : timing delayed one cycle
//   rgb_out                     : pixel colour aligned with blank_out
//   locked                      : high while streaming a frame
//   err_underflow, err_align    : sticky error flags
//   underflow_cnt, frame_cnt    : saturating statistics, only with
//                                 VGA_PIXEL_SOURCE_STATS_EN defined
//
// state    | meaning
// ---------+--------------------------------------------------------------
// SYNC     | discard words until an SOF word sits at the FIFO head
// ARMED    | SOF held at head, waiting for vertical sync
// WAIT_ACT | waiting for the first active pixel of the frame
// STREAM   | one pop per active pixel until the frame is complete
// CHECK    | frame complete, next head word must carry SOF
module vga_pixel_source
   import video_pkg::*;
#(
   parameter int   HDISP           = 800,
   parameter int   VDISP           = 480,
   parameter rgb_t UNDERFLOW_COLOR = 24'hFF00FF
) (
   input  logic               pixel_clk,
   input  logic               pixel_rst_n,
   input  logic               hs_in,
   input  logic               vs_in,
   input  logic               blank_in,
   vga_pixel_source_if.slave  fifo,
   input  logic               err_clr,
   output logic               hs_out,
   output logic               vs_out,
   output logic               blank_out,
   output rgb_t               rgb_out,
   output logic               locked,
   output logic               err_underflow,
   output logic               err_align
`ifdef VGA_PIXEL_SOURCE_STATS_EN
   ,
   output logic [15:0]        underflow_cnt,
   output logic [15:0]        frame_cnt
`endif
);

   localparam int FRAME_PIX = HDISP * VDISP;
   localparam int CNT_W     = $clog2(FRAME_PIX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PIX - 1);

   localparam logic [2:0] S_SYNC     = SYNC;
   localparam logic [2:0] S_ARMED    = ARMED;
   localparam logic [2:0] S_WAIT_ACT = WAIT_ACT;
   localparam logic [2:0] S_STREAM   = STREAM;
   localparam logic [2:0] S_CHECK    = CHECK;

   logic [2:0]       state, state_nxt;
   logic [CNT_W-1:0] pix_cnt, pix_cnt_nxt;
   rgb_t             rgb_nxt;
   fifo_word_t       head;
   logic             have_word;
   logic             pop;
   logic             set_underflow;
   logic             set_align;
   logic             frame_done;

   assign head      = fifo_word_t'(fifo.fifo_rdata);
   assign have_word = !fifo.fifo_empty;

   always_comb begin
      state_nxt     = state;
      pix_cnt_nxt   = pix_cnt;
      rgb_nxt       = '0;
      pop           = 1'b0;
      set_underflow = 1'b0;
      set_align     = 1'b0;
      frame_done    = 1'b0;
      case (state)
         S_SYNC: begin
            if (have_word) begin
               if (head.sof) state_nxt = S_ARMED;
               else          pop       = 1'b1;
            end
         end
         S_ARMED: begin
            if (!vs_in) state_nxt = S_WAIT_ACT;
         end
         S_WAIT_ACT: begin
            if (blank_in) begin
               if (!have_word) begin
                  rgb_nxt       = UNDERFLOW_COLOR;
                  set_underflow = 1'b1;
                  state_nxt     = S_SYNC;
               end else if (head.sof) begin
                  pop         = 1'b1;
                  rgb_nxt     = head.rgb;
                  pix_cnt_nxt = CNT_W'(1);
                  state_nxt   = S_STREAM;
               end else begin
                  // SOF was held at the head since SYNC, so a plain word here
                  // means something else popped the FIFO; start over.
                  set_align = 1'b1;
                  state_nxt = S_SYNC;
               end
            end
         end
         S_STREAM: begin
            // pix_cnt is always 1..FRAME_PIX-1 here, so any SOF is early.
            if (blank_in) begin
               if (!have_word) begin
                  rgb_nxt       = UNDERFLOW_COLOR;
                  set_underflow = 1'b1;
                  pix_cnt_nxt   = '0;
                  state_nxt     = S_SYNC;
               end else if (head.sof) begin
                  rgb_nxt     = UNDERFLOW_COLOR;
                  set_align   = 1'b1;
                  pix_cnt_nxt = '0;
                  state_nxt   = S_ARMED;
               end else begin
                  pop     = 1'b1;
                  rgb_nxt = head.rgb;
                  if (pix_cnt == CNT_LAST) begin
                     pix_cnt_nxt = '0;
                     frame_done  = 1'b1;
                     state_nxt   = S_CHECK;
                  end else begin
                     pix_cnt_nxt = pix_cnt + 1'b1;
                  end
               end
            end
         end
         S_CHECK: begin
            if (blank_in) rgb_nxt = UNDERFLOW_COLOR;
            if (have_word) begin
               if (head.sof) begin
                  state_nxt = S_ARMED;
               end else begin
                  set_align = 1'b1;
                  state_nxt = S_SYNC;
               end
            end
         end
         default: state_nxt = S_SYNC;
      endcase
   end

   assign fifo.fifo_read = pop && pixel_rst_n;

   always_ff @(posedge pixel_clk) begin
      if (!pixel_rst_n) begin
         state         <= S_SYNC;
         pix_cnt       <= '0;
         hs_out        <= 1'b1;
         vs_out        <= 1'b1;
         blank_out     <= 1'b0;
         rgb_out       <= '0;
         locked        <= 1'b0;
         err_underflow <= 1'b0;
         err_align     <= 1'b0;
      end else begin
         state         <= state_nxt;
         pix_cnt       <= pix_cnt_nxt;
         hs_out        <= hs_in;
         vs_out        <= vs_in;
         blank_out     <= blank_in;
         rgb_out       <= rgb_nxt;
         locked        <= (state_nxt == S_STREAM);
         err_underflow <= set_underflow | (err_underflow & ~err_clr);
         err_align     <= set_align | (err_align & ~err_clr);
      end
   end

`ifdef VGA_PIXEL_SOURCE_STATS_EN
   always_ff @(posedge pixel_clk) begin
      if (!pixel_rst_n) begin
         underflow_cnt <= '0;
         frame_cnt     <= '0;
      end else begin
         if (set_underflow && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
         if (frame_done && frame_cnt != 16'hFFFF)        frame_cnt     <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_pixel_source.sv
// Testbench for vga_pixel_source with an 8x4 frame. A queue models the FWFT
// FIFO; the stimulus pushes expected pixel colours into a scoreboard queue and
// a monitor compares them against rgb_out whenever blank_out is high.
// Statistics checks are compiled in with VGA_PIXEL_SOURCE_STATS_EN.
module tb_vga_pixel_source;
   import video_pkg::*;

   localparam int   HD   = 8;
   localparam int   VD   = 4;
   localparam rgb_t UFC  = 24'hFF00FF;
   localparam int   SKIP = -1;

   logic pixel_clk   = 1'b0;
   logic pixel_rst_n = 1'b0;
   logic hs_in       = 1'b1;
   logic vs_in       = 1'b1;
   logic blank_in    = 1'b0;
   logic err_clr     = 1'b0;
   logic hs_out, vs_out, blank_out, locked, err_underflow, err_align;
   rgb_t rgb_out;
`ifdef VGA_PIXEL_SOURCE_STATS_EN
   logic [15:0] underflow_cnt, frame_cnt;
`endif

   vga_pixel_source_if fifo_if();

   vga_pixel_source #(.HDISP(HD), .VDISP(VD), .UNDERFLOW_COLOR(UFC)) dut (
      .pixel_clk     (pixel_clk),
      .pixel_rst_n   (pixel_rst_n),
      .hs_in         (hs_in),
      .vs_in         (vs_in),
      .blank_in      (blank_in),
      .fifo          (fifo_if.slave),
      .err_clr       (err_clr),
      .hs_out        (hs_out),
      .vs_out        (vs_out),
      .blank_out     (blank_out),
      .rgb_out       (rgb_out),
      .locked        (locked),
      .err_underflow (err_underflow),
      .err_align     (err_align)
`ifdef VGA_PIXEL_SOURCE_STATS_EN
      ,
      .underflow_cnt (underflow_cnt),
      .frame_cnt     (frame_cnt)
`endif
   );

   always #5 pixel_clk = ~pixel_clk;

   int          errors = 0;
   int          checks = 0;
   logic [24:0] fq[$];
   int          exp_q[$];
   int          pops = 0;
   logic        rd_s = 1'b0;
   logic        locked_first = 1'b0;
   int          mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // FIFO model: pop decided from fifo_read sampled mid-cycle, head refreshed after the edge.
   initial begin
      fifo_if.fifo_rdata = '0;
      fifo_if.fifo_empty = 1'b1;
   end

   always @(negedge pixel_clk) rd_s = fifo_if.fifo_read;

   always @(posedge pixel_clk) begin
      if (rd_s) begin
         check("pop_nonempty", (fq.size() != 0), 1);
         if (fq.size() != 0) begin
            void'(fq.pop_front());
            pops++;
         end
      end
      #1;
      fifo_if.fifo_empty = (fq.size() == 0);
      fifo_if.fifo_rdata = (fq.size() != 0) ? fq[0] : '0;
   end

   // Scoreboard monitor
   always @(negedge pixel_clk) begin
      if (blank_out === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rgb_extra: got %0h expected no active pixel at %0t", rgb_out, $time);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e != SKIP) check("rgb_px", rgb_out, mon_e);
         end
      end else begin
         check("rgb_blank_zero", rgb_out, 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   task automatic tick();
      @(posedge pixel_clk);
      #1;
   endtask

   task automatic drv(input logic hs, input logic vs, input logic bl);
      hs_in    = hs;
      vs_in    = vs;
      blank_in = bl;
      tick();
   endtask

   task automatic idle(input int n);
      repeat (n) drv(1'b1, 1'b1, 1'b0);
   endtask

   task automatic push_frame(input int base, input int n);
      for (int i = 0; i < n; i++) fq.push_back({(i == 0) ? 1'b1 : 1'b0, 24'(base + i)});
   endtask

   task automatic push_exp(input int base, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(base + i);
   endtask

   task automatic push_skip(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(SKIP);
   endtask

   task automatic do_reset();
      pixel_rst_n = 1'b0;
      err_clr     = 1'b0;
      fq.delete();
      exp_q.delete();
      idle(2);
      pops = 0;
      check("rst_hs_out", hs_out, 1);
      check("rst_vs_out", vs_out, 1);
      check("rst_blank_out", blank_out, 0);
      check("rst_rgb_out", rgb_out, 0);
      check("rst_locked", locked, 0);
      check("rst_err_underflow", err_underflow, 0);
      check("rst_err_align", err_align, 0);
      pixel_rst_n = 1'b1;
   endtask

   // One frame: 2 cycles vsync, 2 blank, VD lines of HD active + 3 blank, 2 idle.
   task automatic run_frame(input int rst_at, input int clr_at);
      int pix;
      pix = 0;
      repeat (2) drv(1'b1, 1'b0, 1'b0);
      repeat (2) drv(1'b1, 1'b1, 1'b0);
      for (int ln = 0; ln < VD; ln++) begin
         for (int x = 0; x < HD; x++) begin
            err_clr = (pix == clr_at);
            if (pix == rst_at) begin
               pixel_rst_n = 1'b0;
               hs_in = 1'b1; vs_in = 1'b1; blank_in = 1'b1;
               #1;
               check("fifo_read_in_reset", fifo_if.fifo_read, 0);
               tick();
               check("midrst_hs_out", hs_out, 1);
               check("midrst_vs_out", vs_out, 1);
               check("midrst_blank_out", blank_out, 0);
               check("midrst_rgb_out", rgb_out, 0);
               check("midrst_locked", locked, 0);
               pixel_rst_n = 1'b1;
            end else begin
               drv(1'b1, 1'b1, 1'b1);
            end
            if (pix == 0) locked_first = locked;
            pix++;
         end
         err_clr = 1'b0;
         drv(1'b0, 1'b1, 1'b0);
         drv(1'b0, 1'b1, 1'b0);
         drv(1'b1, 1'b1, 1'b0);
      end
      idle(2);
   endtask

   initial begin
      // Nominal: two back-to-back frames, RGB = word index
      do_reset();
      push_frame(0, 32);
      push_frame(32, 32);
      idle(10);
      check("nom_locked_armed", locked, 0);
      push_exp(0, 32);
      run_frame(-1, -1);
      check("nom_locked_first", locked_first, 1);
      push_exp(32, 32);
      run_frame(-1, -1);
      check("nom_err_underflow", err_underflow, 0);
      check("nom_err_align", err_align, 0);
      check("nom_drain", exp_q.size(), 0);
      check("nom_pops", pops, 64);
`ifdef VGA_PIXEL_SOURCE_STATS_EN
      check("nom_frame_cnt", frame_cnt, 2);
      check("nom_underflow_cnt", underflow_cnt, 0);
`endif

      // Garbage lead-in: five non-SOF words ahead of the frame
      do_reset();
      for (int i = 0; i < 5; i++) fq.push_back({1'b0, 24'(100 + i)});
      push_frame(0, 32);
      idle(10);
      check("garb_sync_pops", pops, 5);
      push_exp(0, 32);
      run_frame(-1, -1);
      check("garb_err_align", err_align, 0);
      check("garb_drain", exp_q.size(), 0);

      // Underflow at pixel 10, with err_clr raised on the same pixel
      do_reset();
      push_frame(0, 10);
      idle(10);
      push_exp(0, 10);
      exp_q.push_back(int'(UFC));
      push_skip(21);
      run_frame(-1, 10);
      check("uf_err_underflow", err_underflow, 1);
      check("uf_locked", locked, 0);
`ifdef VGA_PIXEL_SOURCE_STATS_EN
      check("uf_underflow_cnt", underflow_cnt, 1);
`endif
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("uf_err_clr", err_underflow, 0);
      push_frame(50, 32);
      idle(10);
      push_exp(50, 32);
      run_frame(-1, -1);
      check("uf_relock", locked_first, 1);
      check("uf_err_underflow_after", err_underflow, 0);
      check("uf_drain", exp_q.size(), 0);

      // Early SOF at word 20
      do_reset();
      push_frame(0, 20);
      push_frame(100, 32);
      idle(10);
      push_exp(0, 20);
      exp_q.push_back(int'(UFC));
      push_skip(11);
      run_frame(-1, -1);
      check("early_err_align", err_align, 1);
      check("early_pops", pops, 20);
      check("early_err_underflow", err_underflow, 0);
      push_exp(100, 32);
      run_frame(-1, -1);
      check("early_relock", locked_first, 1);
      check("early_drain", exp_q.size(), 0);

      // Overlong frame: 33rd word lacks SOF
      do_reset();
      push_frame(0, 32);
      fq.push_back({1'b0, 24'd500});
      push_frame(300, 32);
      idle(10);
      push_exp(0, 32);
      run_frame(-1, -1);
      idle(5);
      check("long_err_align", err_align, 1);
      check("long_pops", pops, 33);
      push_exp(300, 32);
      run_frame(-1, -1);
      check("long_relock", locked_first, 1);
      check("long_drain", exp_q.size(), 0);

      // Reset mid-stream at pixel 15, then three clean frames
      do_reset();
      push_frame(0, 32);
      push_frame(1000, 32);
      push_frame(2000, 32);
      push_frame(3000, 32);
      idle(10);
      push_exp(0, 15);
      push_skip(16);
      run_frame(15, -1);
      check("rst_drain", exp_q.size(), 0);
      push_exp(1000, 32);
      run_frame(-1, -1);
      push_exp(2000, 32);
      run_frame(-1, -1);
      push_exp(3000, 32);
      run_frame(-1, -1);
      check("rst3_drain", exp_q.size(), 0);
      check("rst3_pops", pops, 128);
      check("rst3_err_align", err_align, 0);
      check("rst3_err_underflow", err_underflow, 0);
`ifdef VGA_PIXEL_SOURCE_STATS_EN
      check("rst3_frame_cnt", frame_cnt, 3);
      check("rst3_underflow_cnt", underflow_cnt, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_pixel_source.md
Name: vga_pixel_source

Overview:
- Pixel-domain stage directly upstream of the VGA timing/output stage.
- Pops 24-bit RGB words from a first-word-fall-through (FWFT) pixel FIFO filled by the framebuffer reader.
- Emits one RGB word per active pixel, aligned to the incoming HS/VS/BLANK timing.
- Locks onto frame boundaries using a start-of-frame (SOF) tag bit, detects underflow and misalignment, and resynchronises automatically.

Parameters:
- HDISP, 800, active pixels per line.
- VDISP, 480, active lines per frame.
- UNDERFLOW_COLOR, 24'hFF00FF, colour driven on an active pixel when the FIFO is empty.

Ports:
- pixel_clk  in  1  pixel clock; single clock domain.
- pixel_rst_n  in  1  synchronous reset, active-low.
- hs_in  in  1  horizontal sync from timing generator, active-low.
- vs_in  in  1  vertical sync from timing generator, active-low.
- blank_in  in  1  1 = active display pixel, 0 = blanking.
- fifo_rdata  in  25  FWFT head word: [24] = SOF tag, [23:0] = RGB; valid while fifo_empty=0.
- fifo_empty  in  1  FIFO empty.
- fifo_read  out  1  pop the head word (combinational).
- err_clr  in  1  clears sticky error flags.
- hs_out  out  1  hs_in delayed 1 cycle.
- vs_out  out  1  vs_in delayed 1 cycle.
- blank_out  out  1  blank_in delayed 1 cycle.
- rgb_out  out  24  pixel colour, aligned with blank_out.
- locked  out  1  1 while in STREAM.
- err_underflow  out  1  sticky flag: FIFO empty on an active pixel while streaming.
- err_align  out  1  sticky flag: SOF tag in an unexpected place.

Behaviour:
- Reset (pixel_rst_n=0 at a clock edge):
  - hs_out=1, vs_out=1, blank_out=0, rgb_out=0.
  - locked=0, err_underflow=0, err_align=0, pixel counter=0, state=SYNC.
  - fifo_read=0 during reset.
  - Reset mid-frame aborts the frame immediately; no partial-frame recovery.
- Latency: all outputs are registered, 1 cycle after the corresponding inputs.
- rgb_out=0 whenever the registered blank_out=0.
- Pixel counter width: $clog2(HDISP*VDISP+1).
- fifo_read is asserted only when fifo_empty=0; a pop is never issued on an empty FIFO.
- States:
  - SYNC: discard words, fifo_read = !fifo_empty && !fifo_rdata[24]. When the head is an SOF word, hold it and go to ARMED. An empty FIFO simply waits.
  - ARMED: wait for vs_in=0, then go to WAIT_ACT. No reads.
  - WAIT_ACT: wait for the first blank_in=1.
    - If the FIFO is non-empty and the head has SOF=1: pop, drive the pixel, counter=1, go to STREAM.
    - If the FIFO is empty: drive UNDERFLOW_COLOR, set err_underflow, go to SYNC.
  - STREAM: on each blank_in=1, pop and drive fifo_rdata[23:0]; counter increments.
    - Empty on an active pixel: drive UNDERFLOW_COLOR, set err_underflow, go to SYNC. No further pops this frame.
    - Head with SOF=1 while counter is nonzero and below HDISP*VDISP (early SOF): do not pop, drive UNDERFLOW_COLOR, set err_align, go to ARMED. The SOF word stays at the head.
    - After the pop that makes counter==HDISP*VDISP: counter=0, go to CHECK.
  - CHECK: wait for the FIFO to be non-empty.
    - Head SOF=1: go to ARMED.
    - Head SOF=0 (overlong frame): set err_align, go to SYNC.
    - Active pixels seen while in CHECK drive UNDERFLOW_COLOR (frame already complete; this only occurs on a timing mismatch).
- locked=1 only in STREAM.
- Sticky errors:
  - err_clr=1 clears both flags next cycle.
  - A new error in the same cycle as err_clr wins (flag stays set).

Optional Feature:
- Macro: VGA_PIXEL_SOURCE_STATS_EN.
- When defined, adds two output ports:
  - underflow_cnt [15:0]: counts underflow events.
  - frame_cnt [15:0]: counts frames completed in STREAM.
  - Both saturate at 16'hFFFF, reset to 0, and are not cleared by err_clr.
- When undefined, neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package video_pkg:
  - typedef rgb_t (logic [23:0]).
  - typedef fifo_word_t (packed struct: sof, rgb).
  - typedef enum src_state_t {SYNC, ARMED, WAIT_ACT, STREAM, CHECK}.
  - localparam SOF_BIT = 24.
- No sub-module: one FSM plus a registered output pipeline. Timing delay registers stay inline.

Test Plan (HDISP=8, VDISP=4 in simulation):
- Nominal: FIFO preloaded with 2 frames, SOF on words 0 and 32, RGB = index → locked rises on the first active pixel of frame 1; rgb_out = 0..31 on the blank_out=1 cycles; no error flags set.
- Garbage lead-in: 5 words with SOF=0 ahead of the SOF word → 5 pops in SYNC; first displayed pixel is the SOF word's RGB; err_align stays 0.
- Underflow: FIFO runs empty at pixel 10 → rgb_out=24'hFF00FF at that pixel; err_underflow=1; locked=0; clean relock on the next SOF frame.
- Early SOF: SOF placed at word 20 of a 32-pixel frame → err_align=1; SOF word not popped; next frame displays starting from that word.
- Overlong frame: 33rd word has SOF=0 → err_align=1; that word is discarded in SYNC; relock on the following SOF.
- Reset mid-STREAM at pixel 15: outputs take reset values the next cycle; with VGA_PIXEL_SOURCE_STATS_EN defined, after 3 clean frames frame_cnt=3 and underflow_cnt=0.
